// File: rtl/cmult_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cmult_pkg                                                                |
// | Shared state encoding, default sizing and helpers for cmult_scheduler.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package cmult_pkg;

    localparam int c_NREQ    = 4;
    localparam int c_W       = 12;
    localparam int c_MUL_LAT = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Index width that never collapses to zero bits.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmult_scheduler_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_arbiter                                                               |
// | Combinational round-robin pick: first set request at or after ptr.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module rr_arbiter
    import cmult_pkg::*;
#(
    parameter int NREQ = c_NREQ,
    parameter int ID_W = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] grant_idx,
    output logic            any
);

    int w_idx;

    always_comb begin
        w_idx     = 0;
        any       = 1'b0;
        grant_idx = '0;
        for (int off = 0; off < NREQ; off++) begin
            w_idx = int'(ptr) + off;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            if (!any && req[w_idx]) begin
                any       = 1'b1;
                grant_idx = ID_W'(w_idx);
            end
        end
        grant = any ? (NREQ'(1) << grant_idx) : '0;
    end

endmodule
`default_nettype wire

// File: rtl/cmult_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cmult_scheduler                                                          |
// | Round-robin sequencer sharing one multi-cycle complex multiplier.        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module cmult_scheduler
    import cmult_pkg::*;
#(
    parameter int NREQ    = c_NREQ,
    parameter int W       = c_W,
    parameter int MUL_LAT = c_MUL_LAT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*W-1:0]        req_a,
    input  logic [NREQ*W-1:0]        req_b,
    input  logic [NREQ*W-1:0]        req_c,
    input  logic [NREQ*W-1:0]        req_d,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [$clog2(NREQ)-1:0]  resp_id,
    output logic [2*W-1:0]           resp_real,
    output logic [2*W-1:0]           resp_img,
    output logic [W-1:0]             mul_a,
    output logic [W-1:0]             mul_b,
    output logic [W-1:0]             mul_c,
    output logic [W-1:0]             mul_d,
    output logic                     mul_en,
    input  logic [2*W-1:0]           mul_real,
    input  logic [2*W-1:0]           mul_img
);

    localparam int c_ID_W  = id_width(NREQ);
    localparam int c_CNT_W = id_width(MUL_LAT);

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_ID_W-1:0]   r_rr_ptr;
    logic [c_ID_W-1:0]   r_id;
    logic [W-1:0]        r_a, r_b, r_c, r_d;
    logic                r_mul_en;
    logic                r_resp_valid;
    logic [2*W-1:0]      r_resp_real, r_resp_img;

    logic [NREQ-1:0]     w_grant;
    logic [c_ID_W-1:0]   w_grant_idx;
    logic                w_any;

    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (c_ID_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (r_rr_ptr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx),
        .any       (w_any)
    );

    // Grant is offered only while idle; held low during reset as well.
    assign req_ready  = (r_state == IDLE && !rst) ? w_grant : '0;

    assign resp_valid = r_resp_valid;
    assign resp_id    = r_id;
    assign resp_real  = r_resp_real;
    assign resp_img   = r_resp_img;
    assign mul_a      = r_a;
    assign mul_b      = r_b;
    assign mul_c      = r_c;
    assign mul_d      = r_d;
    assign mul_en     = r_mul_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_rr_ptr     <= '0;
            r_id         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_c          <= '0;
            r_d          <= '0;
            r_mul_en     <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_real  <= '0;
            r_resp_img   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_a      <= req_a[int'(w_grant_idx)*W +: W];
                        r_b      <= req_b[int'(w_grant_idx)*W +: W];
                        r_c      <= req_c[int'(w_grant_idx)*W +: W];
                        r_d      <= req_d[int'(w_grant_idx)*W +: W];
                        r_id     <= w_grant_idx;
                        r_mul_en <= 1'b1;
                        r_state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_mul_en <= 1'b0;
                    r_cnt    <= c_CNT_W'(MUL_LAT - 1);
                    r_state  <= WAIT;
                end
                WAIT: begin
                    // Operands stay in r_a..r_d, so the multiplier inputs hold until capture.
                    if (r_cnt == '0) begin
                        r_resp_real  <= mul_real;
                        r_resp_img   <= mul_img;
                        r_resp_valid <= 1'b1;
                        r_state      <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_rr_ptr     <= (r_id == c_ID_W'(NREQ - 1)) ? '0 : r_id + 1'b1;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cmult_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cmult_scheduler                                                       |
// | Randomized bench with a behavioural multiplier and round-robin model.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_cmult_scheduler;
    import cmult_pkg::*;

    localparam int NREQ    = 4;
    localparam int W       = 12;
    localparam int MUL_LAT = 14;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*W-1:0]     req_a = '0, req_b = '0, req_c = '0, req_d = '0;
    logic                  resp_valid;
    logic                  resp_ready = 1'b0;
    logic [1:0]            resp_id;
    logic [2*W-1:0]        resp_real, resp_img;
    logic [W-1:0]          mul_a, mul_b, mul_c, mul_d;
    logic                  mul_en;
    logic [2*W-1:0]        mul_real, mul_img;

    cmult_scheduler #(.NREQ(NREQ), .W(W), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_d(req_d),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_real(resp_real), .resp_img(resp_img),
        .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c), .mul_d(mul_d), .mul_en(mul_en),
        .mul_real(mul_real), .mul_img(mul_img)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference arithmetic: (a+jb)(c+jd) scaled by 2^-7.
    function automatic logic [2*W-1:0] cm_re(input logic signed [W-1:0] a, b, c, d);
        int p;
        p = (int'(a) * int'(c) - int'(b) * int'(d)) >>> 7;
        return p[2*W-1:0];
    endfunction

    function automatic logic [2*W-1:0] cm_im(input logic signed [W-1:0] a, b, c, d);
        int p;
        p = (int'(a) * int'(d) + int'(b) * int'(c)) >>> 7;
        return p[2*W-1:0];
    endfunction

    // Multiplier stand-in: the result shows up MUL_LAT edges after mul_en is sampled,
    // with junk in every other slot so an off-by-one capture is visible.
    logic [2*W-1:0] pipe_r [MUL_LAT];
    logic [2*W-1:0] pipe_i [MUL_LAT];
    always @(posedge clk) begin
        for (int k = MUL_LAT - 1; k > 0; k--) begin
            pipe_r[k] <= pipe_r[k-1];
            pipe_i[k] <= pipe_i[k-1];
        end
        if (mul_en) begin
            pipe_r[0] <= cm_re(mul_a, mul_b, mul_c, mul_d);
            pipe_i[0] <= cm_im(mul_a, mul_b, mul_c, mul_d);
        end else begin
            pipe_r[0] <= (2*W)'($urandom);
            pipe_i[0] <= (2*W)'($urandom);
        end
    end
    assign mul_real = pipe_r[MUL_LAT-1];
    assign mul_img  = pipe_i[MUL_LAT-1];

    logic signed [W-1:0] opa [NREQ];
    logic signed [W-1:0] opb [NREQ];
    logic signed [W-1:0] opc [NREQ];
    logic signed [W-1:0] opd [NREQ];
    int m_ptr = 0;

    function automatic int exp_grant(input logic [NREQ-1:0] mask, input int ptr);
        for (int off = 0; off < NREQ; off++) begin
            if (mask[(ptr + off) % NREQ]) return (ptr + off) % NREQ;
        end
        return -1;
    endfunction

    task automatic pack_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = opa[i];
            req_b[i*W +: W] = opb[i];
            req_c[i*W +: W] = opc[i];
            req_d[i*W +: W] = opd[i];
        end
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) begin
            opa[i] = W'($urandom);
            opb[i] = W'($urandom);
            opc[i] = W'($urandom);
            opd[i] = W'($urandom);
        end
        pack_ops();
    endtask

    int            obs_gnt, obs_lat, obs_extra_en, obs_cyc;
    bit            obs_onehot, obs_en, obs_ops, obs_rdy_drop;
    logic [1:0]    obs_id;
    logic [2*W-1:0] obs_re, obs_im;

    // Drives one request mask until granted, then follows the operation to resp_valid.
    task automatic run_op(input logic [NREQ-1:0] mask, input bit keep);
        obs_gnt = -1; obs_lat = -1; obs_extra_en = 0; obs_cyc = -1;
        obs_onehot = 0; obs_en = 0; obs_ops = 0; obs_rdy_drop = 0;
        obs_id = 'x; obs_re = 'x; obs_im = 'x;
        req_valid = mask;
        for (int t = 0; t < 60; t++) begin
            #1;
            if (req_ready != '0) begin
                obs_onehot = $onehot(req_ready);
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) obs_gnt = i;
                break;
            end
            @(negedge clk);
        end
        if (obs_gnt < 0) begin
            req_valid = '0;
            return;
        end
        @(posedge clk); #1;
        obs_rdy_drop = (req_ready == '0);
        obs_en       = mul_en;
        obs_ops      = (mul_a === opa[obs_gnt]) && (mul_b === opb[obs_gnt]) &&
                       (mul_c === opc[obs_gnt]) && (mul_d === opd[obs_gnt]);
        if (!keep) req_valid = '0;
        for (int t = 0; t < 60; t++) begin
            @(posedge clk); #1;
            if (resp_valid) begin
                obs_lat = t + 1;
                obs_cyc = cyc;
                break;
            end
            if (mul_en) obs_extra_en++;
        end
        obs_id = resp_id;
        obs_re = resp_real;
        obs_im = resp_img;
    endtask

    task automatic handshake();
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        req_valid = '1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (req_ready !== '0) $display("FAIL reset_ready_in_rst: got %b want 0", req_ready); else n_pass++;
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b want 0", resp_valid); else n_pass++;
        n_checks++; if ({resp_id, resp_real, resp_img} !== '0) $display("FAIL reset_resp: got %h want 0", {resp_id, resp_real, resp_img}); else n_pass++;
        n_checks++; if ({mul_a, mul_b, mul_c, mul_d, mul_en} !== '0) $display("FAIL reset_mul: got %h want 0", {mul_a, mul_b, mul_c, mul_d, mul_en}); else n_pass++;
        m_ptr = 0;
    endtask

    task automatic test_single();
        rand_ops();
        opa[2] = 12'sd100; opb[2] = 12'sd0; opc[2] = 12'sd128; opd[2] = 12'sd0;
        pack_ops();
        run_op(4'b0100, 1'b0);
        n_checks++; if (obs_gnt !== 2) $display("FAIL single_grant: got %0d want 2", obs_gnt); else n_pass++;
        n_checks++; if (obs_onehot !== 1'b1) $display("FAIL single_onehot: got %b want 1", obs_onehot); else n_pass++;
        n_checks++; if (obs_rdy_drop !== 1'b1) $display("FAIL single_ready_one_cycle: got %b want 1", obs_rdy_drop); else n_pass++;
        n_checks++; if (obs_en !== 1'b1) $display("FAIL single_mul_en: got %b want 1", obs_en); else n_pass++;
        n_checks++; if (obs_ops !== 1'b1) $display("FAIL single_mul_operands: got %b want 1", obs_ops); else n_pass++;
        n_checks++; if (obs_lat !== MUL_LAT + 1) $display("FAIL single_latency: got %0d want %0d", obs_lat, MUL_LAT + 1); else n_pass++;
        n_checks++; if (obs_extra_en !== 0) $display("FAIL single_extra_en: got %0d want 0", obs_extra_en); else n_pass++;
        n_checks++; if (obs_id !== 2'd2) $display("FAIL single_id: got %0d want 2", obs_id); else n_pass++;
        n_checks++; if (obs_re !== 24'd100) $display("FAIL single_real: got %0d want 100", obs_re); else n_pass++;
        n_checks++; if (obs_im !== 24'd0) $display("FAIL single_img: got %0d want 0", obs_im); else n_pass++;
        handshake();
        m_ptr = 3;
    endtask

    task automatic test_complex();
        int eg;
        rand_ops();
        opa[1] = 12'sd64; opb[1] = 12'sd32; opc[1] = 12'sd128; opd[1] = -12'sd64;
        pack_ops();
        eg = exp_grant(4'b0010, m_ptr);
        run_op(4'b0010, 1'b0);
        n_checks++; if (obs_gnt !== eg) $display("FAIL complex_grant: got %0d want %0d", obs_gnt, eg); else n_pass++;
        n_checks++; if (obs_re !== 24'd80) $display("FAIL complex_real: got %0d want 80", $signed(obs_re)); else n_pass++;
        n_checks++; if (obs_im !== 24'd0) $display("FAIL complex_img: got %0d want 0", $signed(obs_im)); else n_pass++;
        handshake();
        m_ptr = (eg + 1) % NREQ;
    endtask

    task automatic test_back_to_back();
        int eg, prev_cyc;
        logic [2*W-1:0] er, ei;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        m_ptr = 0;
        prev_cyc = -1;
        resp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            rand_ops();
            eg = exp_grant(4'b1111, m_ptr);
            er = cm_re(opa[eg], opb[eg], opc[eg], opd[eg]);
            ei = cm_im(opa[eg], opb[eg], opc[eg], opd[eg]);
            run_op(4'b1111, 1'b1);
            n_checks++; if (obs_gnt !== eg) $display("FAIL b2b_grant[%0d]: got %0d want %0d", k, obs_gnt, eg); else n_pass++;
            n_checks++; if (obs_id !== 2'(eg)) $display("FAIL b2b_id[%0d]: got %0d want %0d", k, obs_id, eg); else n_pass++;
            n_checks++; if ({obs_re, obs_im} !== {er, ei}) $display("FAIL b2b_data[%0d]: got %h want %h", k, {obs_re, obs_im}, {er, ei}); else n_pass++;
            if (k > 0) begin
                n_checks++; if (obs_cyc - prev_cyc !== MUL_LAT + 3) $display("FAIL b2b_spacing[%0d]: got %0d want %0d", k, obs_cyc - prev_cyc, MUL_LAT + 3); else n_pass++;
            end
            prev_cyc = obs_cyc;
            m_ptr = (eg + 1) % NREQ;
        end
        req_valid = '0;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_back_pressure();
        int eg, eg2;
        logic [NREQ-1:0] mask;
        logic [2*W-1:0] er, ei;
        logic [2+4*W-1:0] snap;
        bit stable, rdy0, en0;
        rand_ops();
        mask = NREQ'($urandom_range(1, 15));
        eg = exp_grant(mask, m_ptr);
        er = cm_re(opa[eg], opb[eg], opc[eg], opd[eg]);
        ei = cm_im(opa[eg], opb[eg], opc[eg], opd[eg]);
        run_op(mask, 1'b0);
        n_checks++; if ({obs_re, obs_im} !== {er, ei}) $display("FAIL bp_data: got %h want %h", {obs_re, obs_im}, {er, ei}); else n_pass++;
        snap = {resp_id, resp_real, resp_img};
        req_valid = '1;
        stable = 1; rdy0 = 1; en0 = 1;
        repeat (20) begin
            @(negedge clk);
            if (resp_valid !== 1'b1 || {resp_id, resp_real, resp_img} !== snap) stable = 0;
            if (req_ready !== '0) rdy0 = 0;
            if (mul_en !== 1'b0) en0 = 0;
        end
        n_checks++; if (!stable) $display("FAIL bp_stable: got unstable want held %h", snap); else n_pass++;
        n_checks++; if (!rdy0) $display("FAIL bp_req_ready: got nonzero want 0"); else n_pass++;
        n_checks++; if (!en0) $display("FAIL bp_mul_en: got pulse want 0"); else n_pass++;
        m_ptr = (eg + 1) % NREQ;
        eg2 = exp_grant(4'b1111, m_ptr);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        n_checks++; if (resp_valid !== 1'b0) $display("FAIL bp_release_valid: got %b want 0", resp_valid); else n_pass++;
        n_checks++; if (req_ready !== NREQ'(1 << eg2)) $display("FAIL bp_release_idle: got %b want %b", req_ready, NREQ'(1 << eg2)); else n_pass++;
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        bit seen_ready, no_resp;
        rand_ops();
        run_op(4'b0100, 1'b0);
        handshake();
        m_ptr = 3;
        req_valid = 4'b0010;
        seen_ready = 0;
        for (int t = 0; t < 20 && !seen_ready; t++) begin
            #1;
            if (req_ready != '0) seen_ready = 1; else @(negedge clk);
        end
        n_checks++; if (!seen_ready) $display("FAIL rstmid_grant: got none want req 1"); else n_pass++;
        @(posedge clk); #1;
        req_valid = '0;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_checks++; if ({req_ready, resp_valid, resp_id, resp_real, resp_img, mul_a, mul_b, mul_c, mul_d, mul_en} !== '0)
            $display("FAIL rstmid_outputs: got %h want 0", {req_ready, resp_valid, resp_id, resp_real, resp_img, mul_a, mul_b, mul_c, mul_d, mul_en});
        else n_pass++;
        @(negedge clk); rst = 1'b0;
        m_ptr = 0;
        no_resp = 1;
        repeat (30) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) no_resp = 0;
        end
        n_checks++; if (!no_resp) $display("FAIL rstmid_no_resp: got resp_valid want none"); else n_pass++;
        rand_ops();
        run_op(4'b1111, 1'b0);
        n_checks++; if (obs_gnt !== 0) $display("FAIL rstmid_next_grant: got %0d want 0", obs_gnt); else n_pass++;
        handshake();
        m_ptr = 1;
    endtask

    task automatic test_wrap();
        int eg;
        rand_ops();
        run_op(4'b0100, 1'b0);
        handshake();
        m_ptr = 3;
        eg = exp_grant(4'b1010, m_ptr);
        run_op(4'b1010, 1'b0);
        n_checks++; if (obs_gnt !== eg) $display("FAIL wrap_first: got %0d want %0d", obs_gnt, eg); else n_pass++;
        handshake();
        m_ptr = (eg + 1) % NREQ;
        eg = exp_grant(4'b0010, m_ptr);
        run_op(4'b0010, 1'b0);
        n_checks++; if (obs_gnt !== eg) $display("FAIL wrap_second: got %0d want %0d", obs_gnt, eg); else n_pass++;
        handshake();
        m_ptr = (eg + 1) % NREQ;
    endtask

    task automatic test_random();
        int eg;
        logic [NREQ-1:0] mask;
        logic [2*W-1:0] er, ei;
        for (int k = 0; k < 20; k++) begin
            rand_ops();
            mask = NREQ'($urandom_range(1, 15));
            eg = exp_grant(mask, m_ptr);
            er = cm_re(opa[eg], opb[eg], opc[eg], opd[eg]);
            ei = cm_im(opa[eg], opb[eg], opc[eg], opd[eg]);
            run_op(mask, 1'b0);
            n_checks++; if (obs_gnt !== eg) $display("FAIL rand_grant[%0d]: got %0d want %0d", k, obs_gnt, eg); else n_pass++;
            n_checks++; if (obs_lat !== MUL_LAT + 1) $display("FAIL rand_latency[%0d]: got %0d want %0d", k, obs_lat, MUL_LAT + 1); else n_pass++;
            n_checks++; if (obs_id !== 2'(eg)) $display("FAIL rand_id[%0d]: got %0d want %0d", k, obs_id, eg); else n_pass++;
            n_checks++; if ({obs_re, obs_im} !== {er, ei}) $display("FAIL rand_data[%0d]: got %h want %h", k, {obs_re, obs_im}, {er, ei}); else n_pass++;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1 handshake();
            m_ptr = (eg + 1) % NREQ;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_complex();
        test_back_to_back();
        test_back_pressure();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
